// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch (I) and data (D)
// accesses over a variable-latency req/ack bus, with D priority, I starvation bound and timeout.
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_IWAIT = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ireq,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] irdata,
  output logic              ivalid,
  input  logic              dreq,
  input  logic              dwe,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dwdata,
  input  logic [2:0]        dctl,
  output logic [DATA_W-1:0] drdata,
  output logic              dvalid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_ctl,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              StallF,
  output logic              StallM,
  output logic              bus_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IBUSY,
    S_DBUSY,
    S_IDONE,
    S_DDONE
  } state_t;

  localparam logic [3:0] IWAIT_MAX = 4'(MAX_IWAIT);
  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [2:0] CTL_WORD  = 3'b010;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_iwait;
  logic [7:0]          r_tcnt;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [2:0]          r_mem_ctl;
  logic [DATA_W-1:0]   r_irdata;
  logic [DATA_W-1:0]   r_drdata;
  logic                r_ivalid;
  logic                r_dvalid;
  logic                r_bus_err;

  logic                w_busy;
  logic                w_grant_d;
  logic                w_grant_i;
  logic                w_finish;
  logic                w_tout;
  logic [DATA_W-1:0]   w_rdata;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    w_next    = r_state;
    w_busy    = 1'b0;
    w_grant_d = 1'b0;
    w_grant_i = 1'b0;
    w_finish  = 1'b0;
    w_tout    = 1'b0;
    w_rdata   = '0;
    case (r_state)
      S_IDLE: begin
        if (dreq && (!ireq || (r_iwait < IWAIT_MAX))) begin
          w_grant_d = 1'b1;
          w_next    = S_DBUSY;
        end else if (ireq) begin
          w_grant_i = 1'b1;
          w_next    = S_IBUSY;
        end
      end
      S_IBUSY, S_DBUSY: begin
        w_busy = 1'b1;
        // An ack in the final allowed cycle still completes normally.
        if (mem_ack) begin
          w_finish = 1'b1;
          w_rdata  = mem_rdata;
        end else if (r_tcnt == TCNT_LAST) begin
          w_finish = 1'b1;
          w_tout   = 1'b1;
        end
        if (w_finish) w_next = (r_state == S_IBUSY) ? S_IDONE : S_DDONE;
      end
      S_IDONE, S_DDONE: w_next = S_IDLE;
      default:          w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      r_state     <= S_IDLE;
      r_iwait     <= '0;
      r_tcnt      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_ctl   <= '0;
      r_irdata    <= '0;
      r_drdata    <= '0;
      r_ivalid    <= 1'b0;
      r_dvalid    <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_ivalid <= 1'b0;
      r_dvalid <= 1'b0;
      if (w_grant_d) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= dwe;
        r_mem_addr  <= daddr;
        r_mem_wdata <= dwdata;
        r_mem_ctl   <= dctl;
        if (ireq) r_iwait <= r_iwait + 4'd1;
      end else if (w_grant_i) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= iaddr;
        r_mem_wdata <= '0;
        r_mem_ctl   <= CTL_WORD;
        r_iwait     <= '0;
      end
      if (w_finish) begin
        r_mem_req <= 1'b0;
        r_tcnt    <= '0;
        if (r_state == S_IBUSY) begin
          r_irdata <= w_rdata;
          r_ivalid <= 1'b1;
        end else begin
          r_drdata <= w_rdata;
          r_dvalid <= 1'b1;
        end
        if (w_tout) r_bus_err <= 1'b1;
      end else if (w_busy) begin
        r_tcnt <= r_tcnt + 8'd1;
      end
    end
  end

  assign irdata    = r_irdata;
  assign ivalid    = r_ivalid;
  assign drdata    = r_drdata;
  assign dvalid    = r_dvalid;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_ctl   = r_mem_ctl;
  assign bus_err   = r_bus_err;
  assign StallF    = ireq & ~r_ivalid;
  assign StallM    = dreq & ~r_dvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a latency-programmable memory responder plus
// one task per scenario with hand-computed expectations.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq;
  logic [31:0] iaddr;
  logic [31:0] irdata;
  logic        ivalid;
  logic        dreq;
  logic        dwe;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [2:0]  dctl;
  logic [31:0] drdata;
  logic        dvalid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_ctl;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        StallF;
  logic        StallM;
  logic        bus_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Responder: acks when mem_req has been high for resp_lat prior cycles.
  bit          resp_en   = 1'b0;
  int          resp_lat  = 0;
  logic [31:0] resp_data = 32'h0;
  logic        resp_ack  = 1'b0;
  logic        stray_ack = 1'b0;
  int          busy_cnt  = 0;

  assign mem_ack   = resp_ack | stray_ack;
  assign mem_rdata = resp_data;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (resp_en && mem_req) begin
      resp_ack = (busy_cnt == resp_lat);
      busy_cnt = busy_cnt + 1;
    end else begin
      resp_ack = 1'b0;
      if (!mem_req) busy_cnt = 0;
    end
  end

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_IWAIT(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .ireq(ireq), .iaddr(iaddr), .irdata(irdata), .ivalid(ivalid),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .dctl(dctl),
    .drdata(drdata), .dvalid(dvalid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ctl(mem_ctl),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .StallF(StallF), .StallM(StallM), .bus_err(bus_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) step();
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_tests++; if (ivalid !== 1'b0 || dvalid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b%b want 00", ivalid, dvalid); end
    n_tests++; if (irdata !== 32'h0 || drdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h %h want 0 0", irdata, drdata); end
    n_tests++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
    n_tests++; if (StallF !== 1'b0 || StallM !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b%b want 00", StallF, StallM); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_single_fetch();
    resp_en = 1'b1; resp_lat = 2; resp_data = 32'h00500093;
    ireq = 1'b1; iaddr = 32'h100;
    step();
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL fetch_launch: got req=%b addr=%h want 1 00000100", mem_req, mem_addr); end
    n_tests++; if (mem_ctl !== 3'b010 || mem_we !== 1'b0) begin n_fail++; $display("FAIL fetch_ctl: got ctl=%b we=%b want 010 0", mem_ctl, mem_we); end
    n_tests++; if (StallF !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_busy: got %b want 1", StallF); end
    step();
    step();
    n_tests++; if (ivalid !== 1'b0 || StallF !== 1'b1) begin n_fail++; $display("FAIL fetch_early: got valid=%b stall=%b want 0 1", ivalid, StallF); end
    step();
    n_tests++; if (ivalid !== 1'b1 || irdata !== 32'h00500093) begin n_fail++; $display("FAIL fetch_done: got valid=%b data=%h want 1 00500093", ivalid, irdata); end
    n_tests++; if (StallF !== 1'b0) begin n_fail++; $display("FAIL fetch_stall_done: got %b want 0", StallF); end
    ireq = 1'b0;
    step();
    n_tests++; if (ivalid !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse: got valid=%b req=%b want 0 0", ivalid, mem_req); end
  endtask

  task automatic test_d_priority();
    resp_en = 1'b1; resp_lat = 1; resp_data = 32'h11111111;
    ireq = 1'b1; iaddr = 32'h104;
    dreq = 1'b1; dwe = 1'b1; daddr = 32'h2000; dwdata = 32'hDEADBEEF; dctl = 3'b010;
    step();
    n_tests++; if (mem_addr !== 32'h2000 || mem_we !== 1'b1) begin n_fail++; $display("FAIL prio_d_first: got addr=%h we=%b want 00002000 1", mem_addr, mem_we); end
    n_tests++; if (mem_wdata !== 32'hDEADBEEF || mem_ctl !== 3'b010) begin n_fail++; $display("FAIL prio_d_data: got %h ctl=%b want deadbeef 010", mem_wdata, mem_ctl); end
    n_tests++; if (StallM !== 1'b1 || StallF !== 1'b1) begin n_fail++; $display("FAIL prio_stalls: got F=%b M=%b want 1 1", StallF, StallM); end
    step();
    step();
    n_tests++; if (dvalid !== 1'b1 || ivalid !== 1'b0) begin n_fail++; $display("FAIL prio_dvalid: got d=%b i=%b want 1 0", dvalid, ivalid); end
    dreq = 1'b0; dwe = 1'b0;
    step();
    step();
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h104 || mem_we !== 1'b0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL prio_i_next: got req=%b addr=%h we=%b wd=%h want 1 00000104 0 0", mem_req, mem_addr, mem_we, mem_wdata); end
    step();
    step();
    n_tests++; if (ivalid !== 1'b1 || irdata !== 32'h11111111) begin n_fail++; $display("FAIL prio_ivalid: got %b %h want 1 11111111", ivalid, irdata); end
    ireq = 1'b0;
    step();
  endtask

  task automatic test_starvation();
    logic [31:0] exp_addr [6];
    exp_addr = '{32'h400, 32'h400, 32'h400, 32'h400, 32'h300, 32'h400};
    resp_en = 1'b1; resp_lat = 0; resp_data = 32'hA5A5A5A5;
    ireq = 1'b1; iaddr = 32'h300;
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h400; dctl = 3'b100;
    for (int k = 0; k < 6; k++) begin
      step();
      n_tests++; if (mem_req !== 1'b1 || mem_addr !== exp_addr[k]) begin n_fail++; $display("FAIL starve_grant%0d: got req=%b addr=%h want 1 %h", k, mem_req, mem_addr, exp_addr[k]); end
      step();
      step();
    end
    ireq = 1'b0; dreq = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    resp_en = 1'b0;
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h500; dctl = 3'b010;
    step();
    for (int k = 2; k <= 8; k++) begin
      step();
      n_tests++; if (mem_req !== 1'b1 || dvalid !== 1'b0) begin n_fail++; $display("FAIL tout_busy%0d: got req=%b valid=%b want 1 0", k, mem_req, dvalid); end
    end
    step();
    n_tests++; if (mem_req !== 1'b0 || dvalid !== 1'b1) begin n_fail++; $display("FAIL tout_abort: got req=%b valid=%b want 0 1", mem_req, dvalid); end
    n_tests++; if (drdata !== 32'h0 || bus_err !== 1'b1) begin n_fail++; $display("FAIL tout_data_err: got %h err=%b want 0 1", drdata, bus_err); end
    dreq = 1'b0;
    step();
    n_tests++; if (bus_err !== 1'b1 || dvalid !== 1'b0) begin n_fail++; $display("FAIL tout_sticky: got err=%b valid=%b want 1 0", bus_err, dvalid); end
  endtask

  task automatic test_reset_mid_busy();
    resp_en = 1'b0;
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h600;
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1; dreq = 1'b0; stray_ack = 1'b1;
    n_tests++; if (mem_req !== 1'b0 || bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req_err: got req=%b err=%b want 0 0", mem_req, bus_err); end
    n_tests++; if (irdata !== 32'h0 || drdata !== 32'h0 || ivalid !== 1'b0 || dvalid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_outputs: got %h %h %b %b want 0 0 0 0", irdata, drdata, ivalid, dvalid); end
    step();
    stray_ack = 1'b0;
    n_tests++; if (dvalid !== 1'b0 || ivalid !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_stray_ack: got d=%b i=%b req=%b want 0 0 0", dvalid, ivalid, mem_req); end
    step();
    n_tests++; if (dvalid !== 1'b0 || ivalid !== 1'b0) begin n_fail++; $display("FAIL rst_stray_late: got d=%b i=%b want 0 0", dvalid, ivalid); end
  endtask

  task automatic test_ack_vs_timeout();
    resp_en = 1'b1; resp_lat = 7; resp_data = 32'h12345678;
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h700; dctl = 3'b010;
    step();
    repeat (7) step();
    n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL race_last_busy: got req=%b want 1", mem_req); end
    step();
    n_tests++; if (dvalid !== 1'b1 || drdata !== 32'h12345678 || bus_err !== 1'b0) begin n_fail++; $display("FAIL race_ack_wins: got %b %h err=%b want 1 12345678 0", dvalid, drdata, bus_err); end
    dreq = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    logic exp_r;
    resp_en = 1'b1; resp_lat = 0; resp_data = 32'h00A00113;
    ireq = 1'b1; iaddr = 32'h800;
    for (int k = 1; k <= 9; k++) begin
      step();
      exp_r = (k % 3 == 1);
      exp_v = (k % 3 == 2);
      n_tests++; if (mem_req !== exp_r || ivalid !== exp_v) begin n_fail++; $display("FAIL b2b_cycle%0d: got req=%b valid=%b want %b %b", k, mem_req, ivalid, exp_r, exp_v); end
    end
    n_tests++; if (irdata !== 32'h00A00113) begin n_fail++; $display("FAIL b2b_data: got %h want 00a00113", irdata); end
    ireq = 1'b0;
    step();
  endtask

  initial begin
    ireq = 1'b0; iaddr = '0; dreq = 1'b0; dwe = 1'b0;
    daddr = '0; dwdata = '0; dctl = '0;
    test_reset();
    test_single_fetch();
    test_d_priority();
    test_starvation();
    test_timeout();
    test_reset_mid_busy();
    test_ack_vs_timeout();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
